// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, select bit and the FSM state encoding
// common to the master and the completers.
package apb_pkg;

   localparam int APB_ADDR_W  = 9;
   localparam int APB_DATA_W  = 8;
   localparam int APB_SEL_BIT = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

   // True when a local offset falls outside a memory of the given depth
   function automatic logic addr_oob(input logic [APB_SEL_BIT-1:0] off, input int unsigned depth);
      return (32'(off) >= depth);
   endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 8 storage for apb_slave_mem: synchronous write, asynchronous read,
// cleared to zero by the asynchronous reset.
module apb_slv_regfile
   import apb_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   wr_en,
   input  logic [APB_SEL_BIT-1:0] wr_addr,
   input  logic [APB_DATA_W-1:0]  wr_data,
   input  logic [APB_SEL_BIT-1:0] rd_addr,
   output logic [APB_DATA_W-1:0]  rd_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [APB_DATA_W-1:0] mem_r [DEPTH];

   // Storage array: whole-array clear on reset, guarded single-byte write
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (wr_en && !addr_oob(wr_addr, DEPTH)) begin
         mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
      end else begin
         mem_r <= mem_r;
      end
   end

   // Asynchronous read port; out-of-range offsets read as zero
   always_comb begin
      rd_data = 8'h00;
      if (!addr_oob(rd_addr, DEPTH)) begin
         rd_data = mem_r[rd_addr[IDX_W-1:0]];
      end else begin
         rd_data = 8'h00;
      end
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a byte-wide local memory, with PSLVERR on bad offsets.
// Wait states are inserted only when APB_SLV_WAIT_EN is defined; otherwise every transfer takes 2 cycles.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  PSEL,
   input  logic                  PEN,
   input  logic                  PWRITE,
   input  logic [APB_ADDR_W-1:0] PADDR,
   input  logic [APB_DATA_W-1:0] PWDATA,
   output logic [APB_DATA_W-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   apb_state_t             state_r;
   logic [APB_SEL_BIT-1:0] off_r;
   logic                   wr_r;
   logic [APB_DATA_W-1:0]  wdata_r;
   logic                   err_r;

   logic                   start_s;
   logic                   bus_acc_s;
   logic                   err_in_s;
   logic                   wait_last_s;
   logic                   mem_we_s;
   logic                   resp_wr_s;
   logic                   resp_err_s;
   logic [APB_SEL_BIT-1:0] rd_addr_s;
   logic [APB_DATA_W-1:0]  rd_data_s;
   logic [APB_DATA_W-1:0]  resp_data_s;
   logic                   unused_s;

   // The select bit is decoded upstream by the master
   assign unused_s  = PADDR[APB_SEL_BIT];

   // The setup cycle is the one in which the bus shows setup form while we are not mid-access
   assign start_s   = (state_r != ACCESS) && PSEL && !PEN;
   assign bus_acc_s = PSEL && PEN;
   assign err_in_s  = addr_oob(PADDR[APB_SEL_BIT-1:0], DEPTH);
   assign mem_we_s  = (state_r == ACCESS) && PREADY && bus_acc_s && wr_r && !err_r;

`ifdef APB_SLV_WAIT_EN
   localparam logic [3:0] WAIT_C = 4'(WAIT_STATES);
   logic [3:0] cnt_r;

   // Wait-state counter: loaded at setup, counts down while the access phase is held
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r <= 4'd0;
      end else if (start_s) begin
         cnt_r <= WAIT_C;
      end else if ((state_r == ACCESS) && !PREADY && bus_acc_s && (cnt_r != 4'd0)) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= 4'd0;
      end
   end

   assign wait_last_s = (cnt_r == 4'd1);
`else
   localparam logic [3:0] WAIT_C = 4'(WAIT_STATES) & 4'd0;
   assign wait_last_s = 1'b1;
`endif

   // Response source: live bus values in the setup cycle, latched values afterwards
   always_comb begin
      resp_wr_s   = wr_r;
      resp_err_s  = err_r;
      rd_addr_s   = off_r;
      resp_data_s = 8'h00;
      if (start_s) begin
         resp_wr_s  = PWRITE;
         resp_err_s = err_in_s;
         rd_addr_s  = PADDR[APB_SEL_BIT-1:0];
      end else begin
         resp_wr_s  = wr_r;
         resp_err_s = err_r;
         rd_addr_s  = off_r;
      end
      if (!resp_wr_s && !resp_err_s) begin
         resp_data_s = rd_data_s;
      end else begin
         resp_data_s = 8'h00;
      end
   end

   apb_slv_regfile #(
      .DEPTH (DEPTH)
   ) u_regfile (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .wr_en   (mem_we_s),
      .wr_addr (off_r),
      .wr_data (wdata_r),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Transfer FSM with registered PREADY/PSLVERR/PRDATA; responses last exactly one cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= IDLE;
         off_r   <= 8'h00;
         wr_r    <= 1'b0;
         wdata_r <= 8'h00;
         err_r   <= 1'b0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= 8'h00;
      end else begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= 8'h00;
         case (state_r)
            IDLE, SETUP: begin
               if (start_s) begin
                  off_r   <= PADDR[APB_SEL_BIT-1:0];
                  wr_r    <= PWRITE;
                  wdata_r <= PWDATA;
                  err_r   <= err_in_s;
                  state_r <= ACCESS;
                  if (WAIT_C == 4'd0) begin
                     PREADY  <= 1'b1;
                     PSLVERR <= err_in_s;
                     PRDATA  <= resp_data_s;
                  end else begin
                     PREADY  <= 1'b0;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (PREADY) begin
                  // A held select means the master may start the next setup immediately
                  state_r <= bus_acc_s ? SETUP : IDLE;
               end else if (!bus_acc_s) begin
                  state_r <= IDLE;
               end else if (wait_last_s) begin
                  PREADY  <= 1'b1;
                  PSLVERR <= err_r;
                  PRDATA  <= resp_data_s;
               end else begin
                  state_r <= ACCESS;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer with a local byte-wide memory. It answers transfers from the team's APB master on one PSEL line; the master decodes PADDR[8] into PSEL1/PSEL2, and one instance hangs off each select.
- Inserts a configurable number of wait states.
- Flags PSLVERR on out-of-range addresses.
- Aborts cleanly on protocol violations.

Parameters:
DEPTH, 64, number of 8-bit memory locations (1..256); valid offsets are 0..DEPTH-1.
WAIT_STATES, 2, PREADY-low cycles inserted in the access phase (0..15); only effective with APB_SLV_WAIT_EN.

Ports:
CLK  in  1  system clock; all flops on rising edge.
RST_N  in  1  asynchronous active-low reset.
PSEL  in  1  slave select (PSEL1 or PSEL2 from master).
PEN  in  1  APB enable (access phase).
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  9  address; bit 8 ignored here (already decoded by master); offset = PADDR[7:0].
PWDATA  in  8  write data.
PRDATA  out  8  read data; valid only while PREADY=1 on a read.
PREADY  out  1  transfer completes in this cycle.
PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (RST_N=0, async): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=8'h00, wait counter=0, all memory locations=8'h00.
- All outputs are registered; no combinational input-to-output path.
- States:
  - IDLE: PSEL=1 and PEN=0 -> SETUP. Else stay in IDLE.
  - SETUP: this is one cycle. At its closing edge, latch offset, PWRITE, PWDATA and err=(offset>=DEPTH). Load counter=WAIT_STATES. If WAIT_STATES=0, assert PREADY, PSLVERR=err and (read) PRDATA at this same edge. Go to ACCESS.
  - ACCESS: PSEL=1 and PEN=1 required.
    - Counter>0: decrement; PREADY stays 0.
    - Counter reaches 0: register PREADY=1 for exactly one cycle, with PSLVERR=err and PRDATA=mem[offset] on a valid read, 0 otherwise.
    - In the PREADY=1 cycle, if PSEL=1 and PEN=1: a valid write commits at the closing edge. Next state is SETUP if the master holds PSEL=1 and PEN=0 back-to-back, else IDLE.
- Latency: PREADY is high in access cycle WAIT_STATES+1 (the 1st access cycle when WAIT_STATES=0). A transfer takes 2+WAIT_STATES cycles.
- Errored write: memory unchanged. Errored read: PRDATA=8'h00.
- Protocol violation (PSEL or PEN drops in ACCESS before PREADY, or PEN=1 seen in IDLE): abort to IDLE, no write, PREADY and PSLVERR stay 0. PEN=1 with PSEL=1 in IDLE is ignored until PSEL/PEN return to setup form.
- PADDR, PWRITE and PWDATA changes after SETUP are ignored; the latched values are used.
- Reset mid-transfer: immediate return to reset values; no partial write.

Optional Feature:
APB_SLV_WAIT_EN
- Defined: WAIT_STATES honoured as above.
- Undefined: counter logic is removed and wait states are forced to 0, so every transfer completes in exactly 2 cycles.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS}, matching the master encoding 2'b00/01/10.
  - APB_ADDR_W=9, APB_DATA_W=8, APB_SEL_BIT=8.
- One sub-module apb_slv_regfile: DEPTH x 8 memory, synchronous write enable, asynchronous read port, async reset clear.
- The FSM, wait counter and response registers stay in apb_slave_mem.

Test Plan:
- Reset mid-access: assert RST_N=0 during the wait of a write to 0x05 -> PREADY=0 at once; later read of 0x05 returns 8'h00.
- Write then read, WAIT_STATES=2: write 8'hA5 to 0x10 -> PREADY=1 in the 3rd access cycle with PSLVERR=0. Read 0x10 -> PRDATA=8'hA5 with PREADY.
- Back-to-back, WAIT_STATES=0: writes 8'h11 to 0x00 then 8'h22 to 0x01 with no IDLE gap -> each completes in 2 cycles. Reads return 8'h11 and 8'h22.
- Out of range, DEPTH=64: write 8'hFF to 0x40 -> PSLVERR=1 with PREADY. Read 0x40 -> PSLVERR=1, PRDATA=8'h00. Memory unchanged.
- Abort: drop PEN during the wait of a write 8'h3C to 0x02 -> no PREADY; read 0x02 returns the old value.
- Macro off: same write/read as the first write/read case with WAIT_STATES=5 -> PREADY in the 1st access cycle.
